pipe_sequencer: RTL
===================

// Module: pipe_sequencer
// PURPOSE
//  Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Merges hazard-stall, branch/jump redirect, data-memory wait and halt requests into per-stage
//  write-enables, flushes and PC-select. Sits between the hazard-stall logic/decoder and the
//  pipeline registers, and keeps saturating stall/flush statistics counters.
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive dmem wait cycles before ERR (>=2)
//  CNT_W        16  width of statistics counters
//  DRAIN_CYC    3   cycles to drain EX/MEM/WB after halt (>=1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      leave IDLE and begin fetching
//  haz_stall  in   1      1 = data hazard on instruction in ID
//  jmp        in   1      jump decoded in ID
//  br_taken   in   1      branch resolved taken in EX
//  halt_req   in   1      halt decoded in ID
//  dmem_req   in   1      MEM stage access in progress
//  dmem_ready in   1      data memory completes this cycle
//  pc_we      out  1      PC write enable
//  pc_sel     out  2      00 seq, 01 branch target, 10 jump target (00 when pc_we=0)
//  ifid_we    out  1      IF/ID write enable
//  ifid_flush out  1      load NOP into IF/ID
//  idex_flush out  1      load bubble into ID/EX
//  back_we    out  1      EX/MEM and MEM/WB write enable
//  state      out  3      0 IDLE,1 RUN,2 MEMW,3 DRAIN,4 HALT,5 ERR
//  halted     out  1      state==HALT
//  err        out  1      state==ERR
//  stall_cnt  out  CNT_W  hazard bubbles inserted, saturating
//  flush_cnt  out  CNT_W  redirect events (branch+jump), saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, wait/drain counters=0, stall_cnt=flush_cnt=0.
//   All enables/flushes 0, pc_sel=00.
//  Outputs are combinational in state + current inputs. Counters and state update on posedge clk.
//  IDLE: all enables 0. start=1 -> RUN next cycle.
//  RUN, first matching row wins:
//   1 dmem_req&!dmem_ready: pc_we=ifid_we=back_we=0, flushes 0. -> MEMW, wait_cnt=1.
//   2 br_taken: pc_we=1, pc_sel=01, ifid_flush=1, idex_flush=1, back_we=1. flush_cnt++.
//     Overrides haz_stall/jmp/halt_req (younger instrs).
//   3 jmp: pc_we=1, pc_sel=10, ifid_flush=1, ifid_we=1, back_we=1. flush_cnt++.
//     Overrides haz_stall (ID holds the jump itself).
//   4 haz_stall: pc_we=0, ifid_we=0, idex_flush=1, back_we=1. stall_cnt++.
//   5 halt_req: pc_we=0, ifid_flush=1, idex_flush=0, back_we=1. -> DRAIN, drain_cnt=0.
//     Halt passes to EX as NOP-equivalent.
//   6 else: pc_we=ifid_we=back_we=1, pc_sel=00, flushes 0.
//  MEMW: all enables 0; wait_cnt++ each cycle.
//   dmem_ready=1: that cycle behaves as RUN row 6, -> RUN.
//   dmem_ready=0 and wait_cnt==MEM_TIMEOUT-1 -> ERR.
//   br_taken/haz_stall ignored in MEMW; upstream holds them since stages are frozen.
//  DRAIN: pc_we=0, ifid_we=0, idex_flush=1, back_we=1 (unless row-1 dmem freeze applies:
//   all 0, drain_cnt holds). drain_cnt++ per advancing cycle; at DRAIN_CYC-1 -> HALT.
//  HALT, ERR: all enables 0, terminal until reset. start ignored.
//  Counters saturate at all-ones and never wrap. Simultaneous br_taken+haz_stall counts flush only.
//  Enable and flush asserted on same register same cycle: flush wins (register loads NOP).
// TESTING
//  T1 reset: rst_n=0 mid-RUN -> state=0 immediately, all enables 0, counters 0.
//   start -> RUN, pc_we=1, pc_sel=00.
//  T2 hazard: haz_stall=1 for 2 cycles in RUN -> pc_we=ifid_we=0, idex_flush=1, back_we=1
//   both cycles; stall_cnt=2.
//  T3 branch priority: br_taken=1 with haz_stall=1,jmp=1 -> pc_sel=01, ifid_flush=idex_flush=1;
//   flush_cnt=1, stall_cnt unchanged.
//  T4 mem wait: dmem_req=1, dmem_ready after 5 cycles -> 5 fully frozen cycles, ready cycle
//   all we=1, back in RUN. Never ready -> err=1 on cycle MEM_TIMEOUT (64).
//  T5 halt: halt_req=1 -> DRAIN 3 cycles with back_we=1, pc_we=0, then halted=1,
//   all enables 0; start=1 no effect.
//  T6 saturation: CNT_W=4, 20 hazard cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: request inputs and per-stage pipeline controls of the pipeline sequencer
interface pipe_sequencer_if;
  logic start, haz_stall, jmp, br_taken, halt_req, dmem_req, dmem_ready;
  logic pc_we, ifid_we, ifid_flush, idex_flush, back_we;
  logic [1:0] pc_sel;
  modport master (
    output start, haz_stall, jmp, br_taken, halt_req, dmem_req, dmem_ready,
    input  pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, back_we
  );
  modport slave (
    input  start, haz_stall, jmp, br_taken, halt_req, dmem_req, dmem_ready,
    output pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, back_we
  );
endinterface

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: merges stall/redirect/dmem-wait/halt requests into 5-stage pipeline controls
module pipe_sequencer #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16,
  parameter int DRAIN_CYC   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_sequencer_if.slave  bus,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam int DW = $clog2(DRAIN_CYC) + 1;
  typedef enum logic [2:0] {IDLE, RUN, MEMW, DRAIN, HALT, ERR} state_t;
  state_t cur, nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic pc_we, ifid_we, ifid_flush, idex_flush, back_we, stall_inc, flush_inc, freeze;
  logic [1:0] pc_sel;
  assign freeze = bus.dmem_req && !bus.dmem_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur       <= IDLE;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur       <= nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  // Row order in RUN is the priority: older instructions (MEM, then EX) win over younger ones.
  always_comb begin
    nxt        = cur;
    wait_nxt   = wait_cnt;
    drain_nxt  = drain_cnt;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    back_we    = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (cur)
      IDLE: nxt = bus.start ? RUN : IDLE;
      RUN:
        if (freeze) begin
          nxt      = MEMW;
          wait_nxt = WW'(1);
        end else if (bus.br_taken) begin
          pc_we      = 1'b1;
          pc_sel     = 2'b01;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          back_we    = 1'b1;
          flush_inc  = 1'b1;
        end else if (bus.jmp) begin
          pc_we      = 1'b1;
          pc_sel     = 2'b10;
          ifid_flush = 1'b1;
          ifid_we    = 1'b1;
          back_we    = 1'b1;
          flush_inc  = 1'b1;
        end else if (bus.haz_stall) begin
          idex_flush = 1'b1;
          back_we    = 1'b1;
          stall_inc  = 1'b1;
        end else if (bus.halt_req) begin
          ifid_flush = 1'b1;
          back_we    = 1'b1;
          nxt        = DRAIN;
          drain_nxt  = '0;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          back_we = 1'b1;
        end
      MEMW: begin
        wait_nxt = wait_cnt + 1'b1;
        if (bus.dmem_ready) begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          back_we = 1'b1;
          nxt     = RUN;
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) nxt = ERR;
      end
      DRAIN:
        if (!freeze) begin
          idex_flush = 1'b1;
          back_we    = 1'b1;
          drain_nxt  = drain_cnt + 1'b1;
          if (drain_cnt == DW'(DRAIN_CYC - 1)) nxt = HALT;
        end
      default: ;
    endcase
  end
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.ifid_we    = ifid_we;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.back_we    = back_we;
  assign state          = cur;
  assign halted         = cur == HALT;
  assign err            = cur == ERR;
endmodule
